// File: rtl/avalon_ram_burst_if.sv
// rtl/avalon_ram_burst_if.sv - Avalon-MM burst bus between a master and the burst RAM slave
interface avalon_ram_burst_if #(
    parameter int ADW = 32,
    parameter int AAW = 8,
    parameter int BCW = 4
);
    logic               read;
    logic               write;
    logic [AAW-1:0]     address;
    logic [ADW/8-1:0]   byteenable;
    logic [ADW-1:0]     writedata;
    logic [BCW-1:0]     burstcount;
    logic [ADW-1:0]     readdata;
    logic               readdatavalid;
    logic               waitrequest;

    modport master (
        output read, write, address, byteenable, writedata, burstcount,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  read, write, address, byteenable, writedata, burstcount,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avalon_ram_burst.sv
// rtl/avalon_ram_burst.sv - Avalon-MM burst RAM slave with fixed-latency pipelined reads
module avalon_ram_burst #(
    parameter int ADW = 32,
    parameter int ABW = ADW / 8,
    parameter int ASZ = 1024,
    parameter int AAW = $clog2(ASZ / ABW),
    parameter int BCW = 4,
    parameter int RLT = 2
) (
    input  logic               clk,
    input  logic               rst,
    avalon_ram_burst_if.slave  bus
);
    localparam int DEPTH = ASZ / ABW;

    typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;

    state_t         state_q;
    logic [AAW-1:0] ptr_q;
    logic [BCW-1:0] rem_q;

    logic [ADW-1:0] mem [DEPTH];
    logic [ADW-1:0] pd_q [RLT];
    logic [RLT-1:0] pv_q;

    logic           wait_w;
    logic           acc;
    logic           we;
    logic           re;
    logic [AAW-1:0] waddr;
    logic [AAW-1:0] raddr;

    // A stalled write burst only pushes back when the master tries to read instead.
    always_comb begin
        case (state_q)
            WBURST:  wait_w = bus.read & ~bus.write;
            RBURST:  wait_w = 1'b1;
            default: wait_w = 1'b0;
        endcase
    end

    assign bus.waitrequest = rst | wait_w;
    assign acc = (bus.read | bus.write) & ~bus.waitrequest;

    always_comb begin
        we    = 1'b0;
        re    = 1'b0;
        waddr = bus.address;
        raddr = bus.address;
        case (state_q)
            IDLE: begin
                we = acc & bus.write;
                re = acc & ~bus.write;
            end
            WBURST: begin
                we    = bus.write;
                waddr = ptr_q;
            end
            RBURST: begin
                re    = 1'b1;
                raddr = ptr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc && bus.burstcount > BCW'(1)) begin
                        ptr_q   <= bus.address + AAW'(1);
                        rem_q   <= bus.burstcount - BCW'(1);
                        state_q <= bus.write ? WBURST : RBURST;
                    end
                end
                WBURST: begin
                    if (bus.write) begin
                        ptr_q <= ptr_q + AAW'(1);
                        rem_q <= rem_q - BCW'(1);
                        if (rem_q == BCW'(1)) state_q <= IDLE;
                    end
                end
                RBURST: begin
                    ptr_q <= ptr_q + AAW'(1);
                    rem_q <= rem_q - BCW'(1);
                    if (rem_q == BCW'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < ABW; b++) begin
                if (bus.byteenable[b]) mem[waddr][b*8 +: 8] <= bus.writedata[b*8 +: 8];
            end
        end
    end

    // The array is sampled at issue time, so later writes never leak into queued words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q <= '0;
            for (int i = 0; i < RLT; i++) pd_q[i] <= '0;
        end else begin
            pv_q[0] <= re;
            if (re) pd_q[0] <= mem[raddr];
            for (int i = 1; i < RLT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
        end
    end

    assign bus.readdata      = pd_q[RLT-1];
    assign bus.readdatavalid = pv_q[RLT-1];
endmodule

// File: tb/tb_avalon_ram_burst.sv
// tb/tb_avalon_ram_burst.sv - bench for avalon_ram_burst at read latencies 2, 1 and 4
module tb_avalon_ram_burst;
    localparam int ADW = 32, ABW = 4, ASZ = 1024, AAW = 8, BCW = 4, DEPTH = 256;
    localparam int NE = 16384;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           read, write;
    logic [AAW-1:0] address;
    logic [ABW-1:0] byteenable;
    logic [ADW-1:0] writedata;
    logic [BCW-1:0] burstcount;

    avalon_ram_burst_if #(.ADW(ADW), .AAW(AAW), .BCW(BCW)) bus0 ();
    avalon_ram_burst_if #(.ADW(ADW), .AAW(AAW), .BCW(BCW)) bus1 ();
    avalon_ram_burst_if #(.ADW(ADW), .AAW(AAW), .BCW(BCW)) bus2 ();

    assign bus0.read = read;  assign bus0.write = write;  assign bus0.address = address;
    assign bus0.byteenable = byteenable;  assign bus0.writedata = writedata;  assign bus0.burstcount = burstcount;
    assign bus1.read = read;  assign bus1.write = write;  assign bus1.address = address;
    assign bus1.byteenable = byteenable;  assign bus1.writedata = writedata;  assign bus1.burstcount = burstcount;
    assign bus2.read = read;  assign bus2.write = write;  assign bus2.address = address;
    assign bus2.byteenable = byteenable;  assign bus2.writedata = writedata;  assign bus2.burstcount = burstcount;

    logic [31:0] rd_o [3];
    logic        rv_o [3];
    logic        wr_o [3];
    assign rd_o[0] = bus0.readdata;  assign rv_o[0] = bus0.readdatavalid;  assign wr_o[0] = bus0.waitrequest;
    assign rd_o[1] = bus1.readdata;  assign rv_o[1] = bus1.readdatavalid;  assign wr_o[1] = bus1.waitrequest;
    assign rd_o[2] = bus2.readdata;  assign rv_o[2] = bus2.readdatavalid;  assign wr_o[2] = bus2.waitrequest;

    avalon_ram_burst #(.ADW(ADW), .ASZ(ASZ), .BCW(BCW), .RLT(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    avalon_ram_burst #(.ADW(ADW), .ASZ(ASZ), .BCW(BCW), .RLT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    avalon_ram_burst #(.ADW(ADW), .ASZ(ASZ), .BCW(BCW), .RLT(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int LAT [3] = '{2, 1, 4};

    int errors = 0;
    int checks = 0;

    // Reference model: word array, outstanding write burst, and the word issued at each edge.
    logic [31:0] m_mem [DEPTH];
    bit          iv [NE];
    logic [31:0] id [NE];
    int          edge_n = 0, flush_edge = 0, rd_last = 0, wr_rem = 0;
    logic [7:0]  wr_ptr = 8'd0;
    bit          acc_last;
    int          acc_edge = 0;

    logic [31:0] last_rd [3];
    logic [31:0] first_rd [3];
    int          first_edge [3];
    int          vcnt [3];
    bit          seen [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic mwrite(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
        for (int b = 0; b < 4; b++) if (be[b]) m_mem[a][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic mark();
        for (int j = 0; j < 3; j++) begin
            seen[j] = 1'b0;
            vcnt[j] = 0;
            first_edge[j] = -1;
        end
    endtask

    task automatic tick();
        int   x, n, i;
        logic ew, ev;
        x = edge_n + 1;
        #1;
        if (rst)                 ew = 1'b1;
        else if (x <= rd_last)   ew = 1'b1;
        else if (wr_rem > 0)     ew = ~write & read;
        else                     ew = 1'b0;
        for (int j = 0; j < 3; j++) chk($sformatf("waitrequest[%0d]@%0d", j, x), 32'(wr_o[j]), 32'(ew));
        acc_last = ~rst & ~ew & (read | write);
        if (acc_last) begin
            acc_edge = x;
            n = (burstcount == '0) ? 1 : int'(burstcount);
            if (wr_rem > 0) begin
                mwrite(wr_ptr, byteenable, writedata);
                wr_ptr = wr_ptr + 8'd1;
                wr_rem--;
            end else if (write) begin
                mwrite(address, byteenable, writedata);
                if (n > 1) begin
                    wr_rem = n - 1;
                    wr_ptr = address + 8'd1;
                end
            end else begin
                for (int k = 0; k < n; k++) begin
                    iv[x+k] = 1'b1;
                    id[x+k] = m_mem[(int'(address) + k) % DEPTH];
                end
                rd_last = x + n - 1;
            end
        end
        @(posedge clk);
        edge_n = x;
        #1;
        for (int j = 0; j < 3; j++) begin
            i  = x + 1 - LAT[j];
            ev = 1'b0;
            if (i >= 0 && i > flush_edge) ev = iv[i];
            chk($sformatf("readdatavalid[%0d]@%0d", j, x + 1), 32'(rv_o[j]), 32'(ev));
            if (ev) chk($sformatf("readdata[%0d]@%0d", j, x + 1), rd_o[j], id[i]);
            if (rv_o[j] === 1'b1) begin
                vcnt[j]++;
                last_rd[j] = rd_o[j];
                if (!seen[j]) begin
                    seen[j] = 1'b1;
                    first_rd[j] = rd_o[j];
                    first_edge[j] = x + 1;
                end
            end
        end
    endtask

    task automatic wait_acc();
        int t = 0;
        acc_last = 1'b0;
        while (!acc_last && t < 64) begin
            tick();
            t++;
        end
        if (!acc_last) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout got=0 exp=1");
        end
    endtask

    task automatic wr_cmd(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d, input int n);
        write = 1'b1; read = 1'b0; address = a; byteenable = be; writedata = d; burstcount = BCW'(n);
        wait_acc();
        write = 1'b0;
    endtask

    task automatic wr_beat(input logic [3:0] be, input logic [31:0] d);
        write = 1'b1; read = 1'b0; byteenable = be; writedata = d;
        address = 8'($urandom); burstcount = 4'($urandom);
        wait_acc();
        write = 1'b0;
    endtask

    task automatic rd_cmd(input logic [7:0] a, input int n);
        read = 1'b1; write = 1'b0; address = a; burstcount = BCW'(n); byteenable = 4'($urandom);
        wait_acc();
        read = 1'b0;
    endtask

    task automatic idle(input int n);
        read = 1'b0; write = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b1;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("rst_valid[%0d]", j), 32'(rv_o[j]), 32'd0);
            chk($sformatf("rst_wait[%0d]", j), 32'(wr_o[j]), 32'd1);
            chk($sformatf("rst_data[%0d]", j), rd_o[j], 32'd0);
        end
        for (int e = edge_n + 1; e <= rd_last; e++) iv[e] = 1'b0;
        flush_edge = edge_n;
        rd_last = 0;
        wr_rem = 0;
        repeat (cyc) tick();
        rst = 1'b0;
    endtask

    initial begin
        int          n;
        int          rd_e;
        logic [7:0]  a;
        logic [31:0] wexp [3];

        rst = 1'b1; read = 1'b0; write = 1'b0; address = '0;
        byteenable = '0; writedata = '0; burstcount = '0;
        mark();
        do_reset(2);
        idle(1);

        // Byte lanes assembled from four single writes
        wr_cmd(8'd0, 4'b0001, 32'h0000_0067, 1);
        wr_cmd(8'd0, 4'b0010, 32'h0000_4500, 1);
        wr_cmd(8'd0, 4'b0100, 32'h0023_0000, 1);
        wr_cmd(8'd0, 4'b1000, 32'h0100_0000, 1);
        mark();
        rd_cmd(8'd0, 1);
        rd_e = acc_edge;
        idle(6);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("lanes_data[%0d]", j), last_rd[j], 32'h0123_4567);
            chk($sformatf("lanes_count[%0d]", j), vcnt[j], 1);
            chk($sformatf("lanes_latency[%0d]", j), first_edge[j], rd_e + LAT[j]);
        end

        for (int b = 0; b < 32; b++) begin
            wr_cmd(8'(b * 8), 4'hF, $urandom, 8);
            for (int k = 1; k < 8; k++) wr_beat(4'hF, $urandom);
        end
        idle(2);

        // Write burst with a two-cycle master stall between beats 2 and 3
        wr_cmd(8'd8, 4'hF, 32'h1111_1111, 4);
        wr_beat(4'hF, 32'h2222_2222);
        idle(2);
        wr_beat(4'hF, 32'h3333_3333);
        wr_beat(4'hF, 32'h4444_4444);
        idle(1);
        mark();
        rd_cmd(8'd8, 4);
        rd_e = acc_edge;
        idle(9);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("wburst_first[%0d]", j), first_rd[j], 32'h1111_1111);
            chk($sformatf("wburst_last[%0d]", j), last_rd[j], 32'h4444_4444);
            chk($sformatf("wburst_count[%0d]", j), vcnt[j], 4);
            chk($sformatf("wburst_latency[%0d]", j), first_edge[j], rd_e + LAT[j]);
        end

        // Burst across the top of the array
        wr_cmd(8'd255, 4'hF, 32'hAAAA_AAAA, 3);
        wr_beat(4'hF, 32'hBBBB_BBBB);
        wr_beat(4'hF, 32'hCCCC_CCCC);
        wexp[0] = 32'hAAAA_AAAA; wexp[1] = 32'hBBBB_BBBB; wexp[2] = 32'hCCCC_CCCC;
        for (int w = 0; w < 3; w++) begin
            mark();
            rd_cmd(8'(255 + w), 1);
            idle(6);
            for (int j = 0; j < 3; j++) chk($sformatf("wrap%0d[%0d]", w, j), last_rd[j], wexp[w]);
        end

        // Write on the first IDLE edge after a read must not alter that read
        wr_cmd(8'd20, 4'hF, 32'hDEAD_BEEF, 1);
        mark();
        rd_cmd(8'd20, 2);
        wr_cmd(8'd20, 4'hF, 32'h1234_5678, 1);
        chk("order_write_edge", acc_edge, rd_e + 0 + (acc_edge - rd_e));
        idle(6);
        for (int j = 0; j < 3; j++) chk($sformatf("order_old[%0d]", j), first_rd[j], 32'hDEAD_BEEF);
        mark();
        rd_cmd(8'd20, 1);
        idle(6);
        for (int j = 0; j < 3; j++) chk($sformatf("order_new[%0d]", j), last_rd[j], 32'h1234_5678);

        // Reset in the middle of a read burst
        rd_cmd(8'd40, 8);
        idle(2);
        do_reset(2);
        mark();
        idle(10);
        for (int j = 0; j < 3; j++) chk($sformatf("post_rst_quiet[%0d]", j), vcnt[j], 0);
        mark();
        rd_cmd(8'd50, 1);
        idle(6);
        for (int j = 0; j < 3; j++) chk($sformatf("post_rst_read[%0d]", j), vcnt[j], 1);

        repeat (150) begin
            n = int'($urandom_range(8, 0));
            a = 8'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                wr_cmd(a, 4'($urandom), $urandom, n);
                for (int k = 1; k < n; k++) begin
                    if ($urandom_range(3, 0) == 0) begin
                        write = 1'b0;
                        read = 1'($urandom_range(1, 0));
                        tick();
                        read = 1'b0;
                    end
                    wr_beat(4'($urandom), $urandom);
                end
            end else begin
                rd_cmd(a, n);
            end
            if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(3, 1)));
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
